branch_redirect_ctrl: RTL and testbench

Sequences control-flow redirection in the pipelined femtoRV32 core. It takes the resolved branch decision from the EX stage (BranchControlUnit output plus the jump flag) and the branch/jump target. It then drives a one-shot PC load and flushes the wrong-path instructions in IF/ID, ID/EX and EX. Pipeline stalls are honoured, so a redirect is never lost or duplicated.

---
 rtl/branch_redirect_ctrl.sv | 134 +++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
//   Control-flow redirect sequencer for the pipelined femtoRV32 core.
//   It takes the resolved branch/jump decision in EX and produces a one-shot
//   PC load plus flushes of IF/ID, ID/EX and the EX stage. Global stalls are
//   honoured, so each redirect is applied exactly once.
//
//   Optional feature: define BRANCH_STATS_EN to add the br_count and
//   br_taken_count statistics outputs (CNT_W bits, wrapping).
//
// Ports
//   clk, rst          core clock, synchronous active-high reset
//   ex_valid          EX holds a valid, non-squashed instruction
//   ex_branch         EX instruction is a conditional branch
//   ex_taken          branch decision from BranchControlUnit
//   ex_jump           EX instruction is JAL/JALR
//   ex_target         branch/jump target
//   stall             global pipeline stall
//   pc_load           load PC with pc_target
//   pc_target         redirect address (meaningful while pc_load=1)
//   flush_ifid        clear IF/ID
//   flush_idex        clear ID/EX
//   squash_ex         suppress EX-stage side effects
//   busy              redirect pending or in progress
//   misalign_err      one-cycle pulse for a misaligned redirect target
//   br_count          (BRANCH_STATS_EN) branches resolved in RUN
//   br_taken_count    (BRANCH_STATS_EN) taken branches resolved in RUN
module branch_redirect_ctrl #(
  parameter int XLEN = 32
`ifdef BRANCH_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_taken,
  input  logic            ex_jump,
  input  logic [XLEN-1:0] ex_target,
  input  logic            stall,
  output logic            pc_load,
  output logic [XLEN-1:0] pc_target,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            squash_ex,
  output logic            busy,
  output logic            misalign_err
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] br_taken_count
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    PENDING  = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [XLEN-1:0] target_q;
  logic            misalign_q;
  logic            redirect_req;
  logic            aligned;
  logic            accept;
  logic            misalign_nx;

  // Requests outside RUN come from wrong-path instructions and are dropped.
  assign redirect_req = ex_valid & ((ex_branch & ex_taken) | ex_jump);
  assign aligned      = (ex_target[1:0] == 2'b00);
  assign accept       = (state == RUN) & redirect_req & aligned;
  assign misalign_nx  = (state == RUN) & redirect_req & ~aligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      target_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      state      <= state_nx;
      misalign_q <= misalign_nx;
      if (accept) target_q <= ex_target;
    end
  end

  always_comb begin
    state_nx   = state;
    pc_load    = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    squash_ex  = 1'b0;
    busy       = 1'b0;
    case (state)
      RUN: begin
        if (accept) state_nx = stall ? PENDING : REDIRECT;
      end
      PENDING: begin
        busy = 1'b1;
        if (!stall) state_nx = REDIRECT;
      end
      REDIRECT: begin
        // Held through stalls: PC and pipe registers are frozen, so the
        // load/flush only takes effect on the first unstalled edge.
        pc_load    = 1'b1;
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        squash_ex  = 1'b1;
        busy       = 1'b1;
        if (!stall) state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  assign pc_target    = target_q;
  assign misalign_err = misalign_q;

`ifdef BRANCH_STATS_EN
  logic count_en;
  assign count_en = (state == RUN) & ex_valid & ex_branch & ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count       <= '0;
      br_taken_count <= '0;
    end else if (count_en) begin
      br_count <= br_count + 1'b1;
      if (ex_taken) br_taken_count <= br_taken_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Testbench for branch_redirect_ctrl: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the redirect.
module tb_branch_redirect_ctrl;
  localparam int XLEN = 32;
`ifdef BRANCH_STATS_EN
  localparam int CW = 4;
`endif

  logic            clk = 1'b0;
  logic            rst, ex_valid, ex_branch, ex_taken, ex_jump, stall;
  logic [XLEN-1:0] ex_target;
  logic            pc_load, flush_ifid, flush_idex, squash_ex, busy, misalign_err;
  logic [XLEN-1:0] pc_target;
`ifdef BRANCH_STATS_EN
  logic [CW-1:0]   br_count, br_taken_count;
`endif

  branch_redirect_ctrl #(
    .XLEN(XLEN)
`ifdef BRANCH_STATS_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_branch(ex_branch),
    .ex_taken(ex_taken), .ex_jump(ex_jump), .ex_target(ex_target),
    .stall(stall), .pc_load(pc_load), .pc_target(pc_target),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .squash_ex(squash_ex),
    .busy(busy), .misalign_err(misalign_err)
`ifdef BRANCH_STATS_EN
    , .br_count(br_count), .br_taken_count(br_taken_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a redirect is an outstanding target that must see two
  // unstalled clock edges (acceptance/release, then application) to retire.
  bit              m_pend;
  int              m_free;
  logic [XLEN-1:0] m_tgt;
  bit              m_mis;
  int              m_cnt, m_tcnt;
  int              loads_seen;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit req;
    if (rst) begin
      m_pend = 0; m_free = 0; m_tgt = '0; m_mis = 0; m_cnt = 0; m_tcnt = 0;
      return;
    end
    req   = ex_valid && ((ex_branch && ex_taken) || ex_jump);
    m_mis = 0;
    if (!m_pend && ex_valid && ex_branch && !stall) begin
      m_cnt++;
      if (ex_taken) m_tcnt++;
    end
    if (m_pend) begin
      if (!stall) m_free++;
      if (m_free == 2) m_pend = 0;
    end else if (req) begin
      if (ex_target[1:0] != 2'b00) m_mis = 1;
      else begin
        m_pend = 1; m_tgt = ex_target; m_free = stall ? 0 : 1;
      end
    end
  endtask

  task automatic check_outputs();
    bit ld;
    ld = m_pend && (m_free >= 1);
    chk("pc_load", {31'd0, pc_load}, {31'd0, ld});
    chk("flush_ifid", {31'd0, flush_ifid}, {31'd0, ld});
    chk("flush_idex", {31'd0, flush_idex}, {31'd0, ld});
    chk("squash_ex", {31'd0, squash_ex}, {31'd0, ld});
    chk("busy", {31'd0, busy}, {31'd0, m_pend});
    chk("pc_target", pc_target, m_tgt);
    chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
`ifdef BRANCH_STATS_EN
    chk("br_count", {28'd0, br_count}, XLEN'(m_cnt % 16));
    chk("br_taken_count", {28'd0, br_taken_count}, XLEN'(m_tcnt % 16));
`endif
    if (pc_load) loads_seen++;
  endtask

  // One clock: drive inputs at negedge, model the edge, check at next negedge.
  task automatic cyc(input bit r, input bit v, input bit b, input bit t, input bit j,
                     input logic [XLEN-1:0] tgt, input bit s);
    rst = r; ex_valid = v; ex_branch = b; ex_taken = t; ex_jump = j;
    ex_target = tgt; stall = s;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input bit s);
    cyc(0, 0, 0, 0, 0, 32'h0, s);
  endtask

  initial begin
    rst = 1; ex_valid = 0; ex_branch = 0; ex_taken = 0; ex_jump = 0;
    ex_target = '0; stall = 0;
    m_pend = 0; m_free = 0; m_tgt = '0; m_mis = 0; m_cnt = 0; m_tcnt = 0;
    loads_seen = 0;
    @(negedge clk);

    // 1: reset, then taken BEQ to 0x40 with no stall
    cyc(1, 0, 0, 0, 0, 32'h0, 0);
    cyc(0, 1, 1, 1, 0, 32'h40, 0);
    chk("t1_pc_load_n1", {31'd0, pc_load}, 32'd1);
    chk("t1_target_n1", pc_target, 32'h40);
    idle(0);
    chk("t1_run_n2", {31'd0, busy}, 32'd0);

    // 2: not-taken BNE, then JAL to 0x100
    cyc(0, 1, 1, 0, 0, 32'h80, 0);
    chk("t2_bne_noload", {31'd0, pc_load}, 32'd0);
    cyc(0, 1, 0, 0, 1, 32'h100, 0);
    chk("t2_jal_target", pc_target, 32'h100);
    idle(0);

    // 3: taken branch under 3 stall cycles, stall again during REDIRECT
    cyc(0, 1, 1, 1, 0, 32'h200, 1);
    idle(1); idle(1);
    chk("t3_pending_busy", {31'd0, busy}, 32'd1);
    chk("t3_pending_noload", {31'd0, pc_load}, 32'd0);
    idle(0);
    chk("t3_redirect", {31'd0, pc_load}, 32'd1);
    idle(1);
    chk("t3_hold_load", {31'd0, pc_load}, 32'd1);
    chk("t3_hold_target", pc_target, 32'h200);
    idle(0);

    // 4: misaligned target, then ignored request in REDIRECT, back-to-back accept
    cyc(0, 1, 1, 1, 0, 32'h42, 0);
    chk("t4_misalign", {31'd0, misalign_err}, 32'd1);
    chk("t4_mis_noload", {31'd0, pc_load}, 32'd0);
    idle(0);
    chk("t4_mis_once", {31'd0, misalign_err}, 32'd0);
    cyc(0, 1, 1, 1, 0, 32'h300, 0);
    cyc(0, 1, 0, 0, 1, 32'h400, 0);   // arrives during REDIRECT: wrong path
    cyc(0, 1, 1, 1, 0, 32'h500, 0);   // correct-path, right after REDIRECT
    chk("t4_b2b_target", pc_target, 32'h500);
    chk("t4_b2b_load", {31'd0, pc_load}, 32'd1);
    idle(0);

    // 5: reset while PENDING abandons the redirect
    cyc(0, 1, 0, 0, 1, 32'h600, 1);
    loads_seen = 0;
    cyc(1, 0, 0, 0, 0, 32'h0, 1);
    chk("t5_reset_target", pc_target, 32'h0);
    idle(0); idle(0); idle(0);
    chk("t5_no_load", loads_seen, 32'd0);
    cyc(0, 1, 1, 1, 0, 32'h700, 0);
    chk("t5_after_reset", pc_target, 32'h700);
    idle(0);

`ifdef BRANCH_STATS_EN
    // 6: 3 taken + 2 not-taken branches and a JAL, then 16 more to wrap
    cyc(1, 0, 0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 1, (i < 3), 0, 32'h800, 0);
      if (i < 3) idle(0);
    end
    cyc(0, 1, 0, 0, 1, 32'h900, 0); idle(0);
    chk("t6_br_count", {28'd0, br_count}, 32'd5);
    chk("t6_taken_count", {28'd0, br_taken_count}, 32'd3);
    for (int i = 0; i < 16; i++) cyc(0, 1, 1, 0, 0, 32'h0, 0);
    chk("t6_wrap", {28'd0, br_count}, 32'd5);
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [XLEN-1:0] tg;
      tg = $urandom;
      if ($urandom_range(0, 7) != 0) tg[1:0] = 2'b00;
      cyc(($urandom_range(0, 63) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), ($urandom_range(0, 3) == 0), tg,
          ($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
